// File: rtl/flex_bypass_fifo.sv
// Single-clock FIFO of any depth >= 2 with an optional same-cycle bypass,
// occupancy flags and sticky overflow/underflow errors.
module flex_bypass_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int BYPASS    = 1,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       pop,
  output logic [WIDTH-1:0]           data_out,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] cnt,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       clear_err,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] arr [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             bypass, byp_take;
  logic             pop_ok, push_ok;
  logic             store, take;
  logic             ovf_evt, udf_evt;

  // Wrap explicitly at DEPTH-1 so non-power-of-two depths never index past the array.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty       = (cnt == '0);
  assign full        = (cnt == CW'(DEPTH));
  assign almost_full = (cnt >= CW'(AF_THRESH));

  assign bypass    = (BYPASS != 0) && empty && push;
  assign out_valid = !reset && (!empty || bypass);
  assign data_out  = ((BYPASS != 0) && empty) ? data_in : arr[rd_ptr];

  assign pop_ok   = pop && out_valid;
  assign push_ok  = !reset && push && (!full || pop_ok);
  // A bypassed push+pop hands data_in straight through and leaves storage alone.
  assign byp_take = bypass && pop_ok;
  assign store    = push_ok && !byp_take;
  assign take     = pop_ok && !byp_take;

  assign ovf_evt = !reset && push && !push_ok;
  assign udf_evt = !reset && pop && !pop_ok;

  always_ff @(posedge clk) begin
    if (store) arr[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (store) wr_ptr <= ptr_inc(wr_ptr);
      if (take)  rd_ptr <= ptr_inc(rd_ptr);
      case ({store, take})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // A fresh error in the same cycle as clear_err keeps its flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_evt || (overflow  && !clear_err);
      underflow <= udf_evt || (underflow && !clear_err);
    end
  end
endmodule

// File: tb/tb_flex_bypass_fifo.sv
// Directed bench: DEPTH=5 FIFO with bypass (dut) and without bypass (dut_nb).
module tb_flex_bypass_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_push = 0, a_pop = 0, a_clr = 0;
  logic [7:0] a_din = '0;
  logic [7:0] a_dout;
  logic       a_ov, a_empty, a_full, a_af, a_ovf, a_udf;
  logic [2:0] a_cnt;
  logic       b_push = 0, b_pop = 0, b_clr = 0;
  logic [7:0] b_din = '0;
  logic [7:0] b_dout;
  logic       b_ov, b_empty, b_full, b_af, b_ovf, b_udf;
  logic [2:0] b_cnt;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flex_bypass_fifo #(.WIDTH(8), .DEPTH(5), .BYPASS(1)) dut (
    .clk(clk), .reset(rst), .push(a_push), .data_in(a_din), .pop(a_pop),
    .data_out(a_dout), .out_valid(a_ov), .cnt(a_cnt), .empty(a_empty),
    .full(a_full), .almost_full(a_af), .clear_err(a_clr),
    .overflow(a_ovf), .underflow(a_udf));

  flex_bypass_fifo #(.WIDTH(8), .DEPTH(5), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(rst), .push(b_push), .data_in(b_din), .pop(b_pop),
    .data_out(b_dout), .out_valid(b_ov), .cnt(b_cnt), .empty(b_empty),
    .full(b_full), .almost_full(b_af), .clear_err(b_clr),
    .overflow(b_ovf), .underflow(b_udf));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a;
    a_push = 0; a_pop = 0; a_clr = 0;
  endtask

  task automatic test_reset;
    rst = 1; a_push = 1; a_din = 8'hEE; a_pop = 1;
    tick; tick;
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL reset_ov got %0b exp 0", a_ov); end
    idle_a; tick;
    checks++; if (a_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", a_cnt); end
    checks++; if ({a_empty, a_full, a_af} !== 3'b100) begin errors++; $display("FAIL reset_flags got %b exp 100", {a_empty, a_full, a_af}); end
    checks++; if ({a_ovf, a_udf, b_ovf, b_udf} !== 4'b0000) begin errors++; $display("FAIL reset_err got %b exp 0000", {a_ovf, a_udf, b_ovf, b_udf}); end
    rst = 0; tick;
  endtask

  task automatic test_bypass;
    a_push = 1; a_din = 8'hA5; a_pop = 1; #1;
    checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL byp_ov got %0b exp 1", a_ov); end
    checks++; if (a_dout !== 8'hA5) begin errors++; $display("FAIL byp_data got %h exp a5", a_dout); end
    tick; idle_a; #1;
    checks++; if (a_cnt !== 3'd0 || a_empty !== 1'b1) begin errors++; $display("FAIL byp_cnt got %0d/%0b exp 0/1", a_cnt, a_empty); end
    checks++; if (a_udf !== 1'b0 || a_ovf !== 1'b0) begin errors++; $display("FAIL byp_err got %0b%0b exp 00", a_ovf, a_udf); end
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 5; i++) begin
      a_push = 1; a_din = 8'(i); tick;
      checks++; if (a_cnt !== 3'(i)) begin errors++; $display("FAIL fill_cnt%0d got %0d exp %0d", i, a_cnt, i); end
      checks++; if (a_af !== (i >= 4) || a_full !== (i == 5)) begin errors++; $display("FAIL fill_flags%0d got af=%0b full=%0b", i, a_af, a_full); end
    end
    a_din = 8'h06; tick; idle_a;
    checks++; if (a_ovf !== 1'b1 || a_cnt !== 3'd5) begin errors++; $display("FAIL ovf got ovf=%0b cnt=%0d exp 1/5", a_ovf, a_cnt); end
    for (int i = 1; i <= 5; i++) begin
      a_pop = 1; #1;
      checks++; if (a_ov !== 1'b1 || a_dout !== 8'(i)) begin errors++; $display("FAIL drain%0d got %h v=%0b exp %h", i, a_dout, a_ov, 8'(i)); end
      tick;
    end
    idle_a; #1;
    checks++; if (a_empty !== 1'b1 || a_cnt !== 3'd0) begin errors++; $display("FAIL drain_empty got %0b/%0d exp 1/0", a_empty, a_cnt); end
    a_clr = 1; tick; idle_a;
    checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf got %0b exp 0", a_ovf); end
  endtask

  task automatic test_full_pushpop;
    logic [7:0] exp_q [5];
    exp_q = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h77};
    for (int i = 0; i < 5; i++) begin a_push = 1; a_din = 8'h11 + 8'(i); tick; end
    a_push = 1; a_din = 8'h77; a_pop = 1; #1;
    checks++; if (a_dout !== 8'h11) begin errors++; $display("FAIL fpp_head got %h exp 11", a_dout); end
    tick; idle_a; #1;
    checks++; if (a_ovf !== 1'b0 || a_cnt !== 3'd5) begin errors++; $display("FAIL fpp_state got ovf=%0b cnt=%0d exp 0/5", a_ovf, a_cnt); end
    for (int i = 0; i < 5; i++) begin
      a_pop = 1; #1;
      checks++; if (a_dout !== exp_q[i]) begin errors++; $display("FAIL fpp_out%0d got %h exp %h", i, a_dout, exp_q[i]); end
      tick;
    end
    idle_a;
  endtask

  task automatic test_wrap;
    logic [7:0] model [$];
    logic [7:0] nxt;
    logic [7:0] exp_v;
    nxt = 8'h20;
    for (int k = 0; k < 12; k++) begin
      idle_a;
      if (k % 3 != 2) begin
        a_push = 1; a_din = nxt; model.push_back(nxt); nxt = nxt + 8'd1;
      end else begin
        a_pop = 1; #1; exp_v = model.pop_front();
        checks++; if (a_dout !== exp_v) begin errors++; $display("FAIL wrap_out%0d got %h exp %h", k, a_dout, exp_v); end
      end
      tick;
    end
    idle_a; #1;
    checks++; if (a_cnt !== 3'd4) begin errors++; $display("FAIL wrap_cnt got %0d exp 4", a_cnt); end
    while (model.size() > 0) begin
      a_pop = 1; #1; exp_v = model.pop_front();
      checks++; if (a_dout !== exp_v) begin errors++; $display("FAIL wrap_drain got %h exp %h", a_dout, exp_v); end
      tick;
    end
    idle_a; #1;
    checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %0b exp 1", a_empty); end
  endtask

  task automatic test_nobypass;
    b_push = 1; b_din = 8'h3C; b_pop = 1; #1;
    checks++; if (b_ov !== 1'b0) begin errors++; $display("FAIL nb_ov0 got %0b exp 0", b_ov); end
    tick; b_push = 0; b_pop = 0; #1;
    checks++; if (b_udf !== 1'b1) begin errors++; $display("FAIL nb_udf got %0b exp 1", b_udf); end
    checks++; if (b_ov !== 1'b1 || b_dout !== 8'h3C || b_cnt !== 3'd1) begin errors++; $display("FAIL nb_data got v=%0b d=%h c=%0d exp 1/3c/1", b_ov, b_dout, b_cnt); end
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < 6; i++) begin a_push = 1; a_din = 8'h40 + 8'(i); tick; end
    idle_a; a_pop = 1; tick; tick; idle_a; #1;
    checks++; if (a_cnt !== 3'd3 || a_ovf !== 1'b1) begin errors++; $display("FAIL mr_pre got cnt=%0d ovf=%0b exp 3/1", a_cnt, a_ovf); end
    rst = 1; #1;
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL mr_ov_in_reset got %0b exp 0", a_ov); end
    tick; rst = 0; #1;
    checks++; if (a_cnt !== 3'd0 || a_empty !== 1'b1 || a_ovf !== 1'b0 || a_ov !== 1'b0) begin errors++; $display("FAIL mr_post got cnt=%0d e=%0b ovf=%0b v=%0b", a_cnt, a_empty, a_ovf, a_ov); end
    a_clr = 1; a_pop = 1; tick; idle_a; #1;
    checks++; if (a_udf !== 1'b1) begin errors++; $display("FAIL mr_setwins got %0b exp 1", a_udf); end
  endtask

  initial begin
    test_reset;
    test_bypass;
    test_fill;
    test_full_pushpop;
    test_wrap;
    test_nobypass;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flex_bypass_fifo.md
Name: flex_bypass_fifo

Overview:
- Parametrised single-clock FIFO with an optional same-cycle bypass from input to output, for use where simple_bypass_fifo's power-of-two depth and missing status are insufficient.
- Adds any DEPTH >= 2 with explicit wrap-around, full/empty/almost_full flags, an output-valid qualifier, and overflow/underflow protection with sticky error flags.
- BYPASS is selectable at elaboration time.
- Sits between pipeline stages and queues transactions; the consumer reads data_out in the same cycle it pops.

Parameters:
- WIDTH, 8, data bits per entry.
- DEPTH, 8, number of storage entries; any integer >= 2, need not be a power of two.
- BYPASS, 1, 1 = a push to an empty FIFO is visible on data_out in the same cycle and may be popped that cycle; 0 = data is visible the cycle after the push.
- AF_THRESH, DEPTH-1, almost_full asserts when cnt >= AF_THRESH; legal range 1..DEPTH.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- push  in  1  enqueue request.
- data_in  in  WIDTH  data, timed with push.
- pop  in  1  dequeue request, same cycle as data_out is consumed.
- data_out  out  WIDTH  oldest entry (or data_in on bypass); valid when out_valid.
- out_valid  out  1  data_out holds real data; a pop is legal this cycle.
- cnt  out  $clog2(DEPTH+1)  stored entries, reflecting last cycle's push/pop; 0..DEPTH.
- empty  out  1  cnt == 0.
- full  out  1  cnt == DEPTH.
- almost_full  out  1  cnt >= AF_THRESH.
- clear_err  in  1  clears the sticky error flags.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop was ignored.

Behaviour:
- Reset: rd_ptr = wr_ptr = 0, cnt = 0, empty = 1, full = 0, almost_full = 0 (AF_THRESH >= 1), overflow = underflow = 0. While reset is high, push/pop are ignored and out_valid is forced to 0. Reset mid-operation discards all contents; storage array contents are not reset.
- Bypass condition: bypass = BYPASS && cnt == 0 && push. Whenever BYPASS = 0, bypass = 0.
- out_valid = (cnt != 0) || bypass, combinational.
- data_out = data_in when cnt == 0 and BYPASS = 1; otherwise arr[rd_ptr]. Zero-latency combinational read.
- Pop acceptance: pop_ok = pop && out_valid.
- Push acceptance: push_ok = push && (!full || pop_ok). Push at full together with an accepted pop is accepted.
- Bypass push+pop (bypass && pop): nothing is written, pointers and cnt are unchanged, and data_in is consumed directly.
- Otherwise push_ok writes arr[wr_ptr] <= data_in and advances wr_ptr. pop_ok advances rd_ptr.
- Pointer wrap: when a pointer equals DEPTH-1, it advances to 0, not to the next power of two.
- Count: cnt += 1 on store-only, cnt -= 1 on pop-only, unchanged otherwise. cnt never leaves 0..DEPTH.
- Overflow: push && !push_ok sets overflow; the data is dropped and state is unchanged.
- Underflow: pop && !pop_ok sets underflow; the pop is ignored. An accompanying push is still accepted.
- Error clearing: clear_err clears both sticky flags next cycle. If a new error occurs in the same cycle as clear_err, set wins.
- Flags are registered-equivalent functions of cnt and update the cycle after the causing push/pop.
- Latency:
  - BYPASS = 1 and empty: push-to-data_out is 0 cycles.
  - Otherwise: 1 cycle when the FIFO is empty, and data appears in order behind earlier entries.

Test Plan:
- WIDTH = 8, DEPTH = 5, BYPASS = 1, empty: push 0xA5 with pop in the same cycle -> out_valid = 1, data_out = 0xA5; next cycle cnt = 0, empty = 1.
- DEPTH = 5: push 0x01..0x05 on consecutive cycles -> cnt reaches 5, full = 1, almost_full = 1 from cnt = 4. A push of 0x06 is dropped and overflow = 1. Then 5 pops return 0x01..0x05 in order.
- Wrap-around with DEPTH = 5: 12 cycles of alternating 2 pushes / 1 pop with incrementing data -> output sequence strictly increasing with no gaps. Pointers wrap 4 -> 0 and are never 5..7.
- Full plus simultaneous push 0x77 and pop -> no overflow, cnt stays 5, and 0x77 is returned last.
- BYPASS = 0, empty: push 0x3C with pop -> out_valid = 0 and underflow = 1, but 0x3C is stored. Next cycle out_valid = 1, data_out = 0x3C, cnt = 1.
- Mid-operation reset with cnt = 3 and overflow = 1 -> next cycle cnt = 0, empty = 1, overflow = 0, out_valid = 0. Then clear_err together with a pop on empty -> underflow = 1, because set wins.
